// File: rtl/timer_arb_pkg.sv
// Package: timer_arb_pkg
// Shared definitions for the interval timer arbiter: FSM state encoding and
// the requester-index width helper.
package timer_arb_pkg;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  typedef enum logic [1:0] {
    StIdle = IDLE,
    StRun  = RUN,
    StDone = DONE
  } state_e;

  // ID_W = $clog2(N_REQ), kept at least 1 bit wide.
  function automatic int unsigned id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Module: rr_pick
// Combinational requester picker.
// Default build: round-robin, search starts at pointer and wraps N_REQ-1 -> 0.
// With TIMER_ARB_FIXED_PRIO_EN defined: fixed priority, lowest asserted index
// wins and pointer is ignored.
// Ports:
//   req     in   N_REQ  request vector
//   pointer in   ID_W   round-robin start index
//   onehot  out  N_REQ  one-hot winner (zero when no request)
//   index   out  ID_W   winner index (zero when no request)
//   valid   out  1      any request present
module rr_pick
  import timer_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned ID_W = id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  pointer,
  output logic [N_REQ-1:0] onehot,
  output logic [ID_W-1:0]  index,
  output logic             valid
);

`ifdef TIMER_ARB_FIXED_PRIO_EN
  logic unused_pointer;
  assign unused_pointer = ^pointer;

  always_comb begin
    onehot = '0;
    index  = '0;
    valid  = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!valid && req[ID_W'(i)]) begin
        valid = 1'b1;
        index = ID_W'(i);
      end
    end
    if (valid) onehot[index] = 1'b1;
  end
`else
  int unsigned k;
  logic [ID_W-1:0] pos;

  always_comb begin
    onehot = '0;
    index  = '0;
    valid  = 1'b0;
    k      = 0;
    pos    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      k = 32'(pointer) + i;
      if (k >= N_REQ) k = k - N_REQ;
      pos = ID_W'(k);
      if (!valid && req[pos]) begin
        valid = 1'b1;
        index = pos;
      end
    end
    if (valid) onehot[index] = 1'b1;
  end
`endif

endmodule

// File: rtl/interval_timer_arbiter.sv
// Module: interval_timer_arbiter
// Shares one prescaled interval timer among N_REQ requesters. A winner is
// granted the timer, which counts ticks*PRESCALE clk cycles, then pulses done
// to the owner for one cycle. Dropping req while running aborts silently.
// Build option: TIMER_ARB_FIXED_PRIO_EN selects fixed priority (lowest index
// wins) instead of the default round-robin arbitration.
// Ports:
//   clk        in   1            clock, posedge
//   reset      in   1            synchronous, active-high
//   req        in   N_REQ        level requests
//   req_ticks  in   N_REQ*CNT_W  tick count per requester, slice i*CNT_W
//   grant      out  N_REQ        registered one-hot owner (or zero)
//   done       out  N_REQ        registered one-cycle completion pulse
//   busy       out  1            timer owned (RUN or DONE)
//   cur_id     out  ID_W         index of current/last owner
//   remaining  out  CNT_W        ticks left in current interval
module interval_timer_arbiter
  import timer_arb_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned PRESCALE = 100,
  localparam int unsigned ID_W    = id_w(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] req_ticks,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [ID_W-1:0]        cur_id,
  output logic [CNT_W-1:0]       remaining
);

  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic [ID_W-1:0]   cur_id_q, cur_id_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [PS_W-1:0]   presc_q, presc_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;

  logic [N_REQ-1:0]  pick_onehot;
  logic [ID_W-1:0]   pick_index;
  logic              pick_valid;
  logic [CNT_W-1:0]  win_ticks;
  logic              owner_req;
  logic              presc_wrap;
  logic [ID_W-1:0]   next_ptr;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req     (req),
    .pointer (ptr_q),
    .onehot  (pick_onehot),
    .index   (pick_index),
    .valid   (pick_valid)
  );

  always_comb begin
    win_ticks = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick_index == ID_W'(i)) win_ticks = req_ticks[i*CNT_W +: CNT_W];
    end
  end

  assign owner_req  = req[cur_id_q];
  assign presc_wrap = (presc_q == PS_W'(PRESCALE - 1));
  // Explicit wrap so non-power-of-two N_REQ stays in range.
  assign next_ptr   = (cur_id_q == ID_W'(N_REQ - 1)) ? '0 : cur_id_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    done_d      = '0;
    cur_id_d    = cur_id_q;
    remaining_d = remaining_q;
    presc_d     = presc_q;
    ptr_d       = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant_d     = pick_onehot;
          cur_id_d    = pick_index;
          remaining_d = win_ticks;
          presc_d     = '0;
          if (win_ticks == '0) begin
            state_d = StDone;
            done_d  = pick_onehot;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        // Withdrawal takes precedence over a coincident final decrement.
        if (!owner_req) begin
          grant_d     = '0;
          remaining_d = '0;
          presc_d     = '0;
          ptr_d       = next_ptr;
          state_d     = StIdle;
        end else if (presc_wrap) begin
          presc_d = '0;
          if (remaining_q != '0) remaining_d = remaining_q - 1'b1;
          if (remaining_q == CNT_W'(1)) begin
            state_d = StDone;
            done_d  = grant_q;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      StDone: begin
        grant_d = '0;
        ptr_d   = next_ptr;
        state_d = StIdle;
      end
      default: begin
        grant_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      done_q      <= '0;
      cur_id_q    <= '0;
      remaining_q <= '0;
      presc_q     <= '0;
      ptr_q       <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      cur_id_q    <= cur_id_d;
      remaining_q <= remaining_d;
      presc_q     <= presc_d;
      ptr_q       <= ptr_d;
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign busy      = (state_q != StIdle);
  assign cur_id    = cur_id_q;
  assign remaining = remaining_q;

endmodule

// File: tb/tb_interval_timer_arbiter.sv
// Testbench: tb_interval_timer_arbiter
// Directed scenarios with literal expectations plus randomized traffic, all
// outputs compared every cycle against a cycle-count reference model.
module tb_interval_timer_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned P  = 4;
  localparam int unsigned IW = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_ticks = '0;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           busy;
  logic [IW-1:0]  cur_id;
  logic [W-1:0]   remaining;

  interval_timer_arbiter #(
    .N_REQ    (N),
    .CNT_W    (W),
    .PRESCALE (P)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_ticks (req_ticks),
    .grant     (grant),
    .done      (done),
    .busy      (busy),
    .cur_id    (cur_id),
    .remaining (remaining)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 timing, 2 done-pulse cycle.
  // The interval is tracked as a plain count of clk cycles left.
  int m_phase = 0, m_owner = 0, m_last = 0, m_ptr = 0, m_cycles = 0, m_w = 0;
  bit m_ok = 1'b0;

  function automatic int pick(input logic [N-1:0] r, input int ptr);
`ifdef TIMER_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (r[i]) return i;
`else
    for (int i = 0; i < N; i++) if (r[(ptr + i) % N]) return (ptr + i) % N;
`endif
    return 0;
  endfunction

  function automatic int ticks_of(input int i);
    logic [W-1:0] t;
    t = req_ticks[i*W +: W];
    return int'(t);
  endfunction

  function automatic int idx_of(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0; m_owner = 0; m_last = 0; m_ptr = 0; m_cycles = 0; m_ok = 1'b1;
    end else if (m_ok) begin
      case (m_phase)
        0: if (req != '0) begin
          m_w      = pick(req, m_ptr);
          m_owner  = m_w;
          m_last   = m_w;
          m_cycles = ticks_of(m_w) * P;
          m_phase  = (m_cycles == 0) ? 2 : 1;
        end
        1: if (!req[m_owner]) begin
          m_phase  = 0;
          m_ptr    = (m_owner + 1) % N;
          m_cycles = 0;
        end else begin
          m_cycles--;
          if (m_cycles == 0) m_phase = 2;
        end
        default: begin
          m_phase = 0;
          m_ptr   = (m_owner + 1) % N;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      check("model_grant", grant, (m_phase != 0) ? (32'd1 << m_owner) : 32'd0);
      check("model_done", done, (m_phase == 2) ? (32'd1 << m_owner) : 32'd0);
      check("model_busy", busy, (m_phase != 0) ? 32'd1 : 32'd0);
      check("model_cur_id", cur_id, m_last);
      check("model_remaining", remaining, (m_phase == 1) ? (m_cycles + P - 1) / P : 0);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_ticks(input int i, input int v);
    req_ticks[i*W +: W] = W'(v);
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (done == '0 && n < limit) begin
      tick();
      n++;
    end
  endtask

  int n;
  int got[5];
  int exp_order[5];
  int cnt;
  logic [N-1:0] prev;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values.
    do_reset();
    check("reset_grant", grant, 0);
    check("reset_busy", busy, 0);
    check("reset_remaining", remaining, 0);

    // Single request, 3 ticks: done 12 cycles after grant.
    set_ticks(1, 3);
    req = 4'b0010;
    tick();
    check("t1_grant", grant, 4'b0010);
    check("t1_remaining", remaining, 3);
    wait_done(40, n);
    check("t1_done_delay", n, 12);
    check("t1_done", done, 4'b0010);
    req = '0;
    tick();
    check("t1_grant_off", grant, 0);
    check("t1_busy_off", busy, 0);

    // Two simultaneous requests, pointer 0: grant 0 then 2, six cycles apart.
    do_reset();
    set_ticks(0, 1);
    set_ticks(2, 1);
    req = 4'b0101;
    tick();
    check("t2_first", grant, 4'b0001);
    n = 0;
    while (grant != 4'b0100 && n < 30) begin
      if (done[0]) req[0] = 1'b0;
      tick();
      n++;
    end
    check("t2_gap", n, 6);
    wait_done(30, n);
    check("t2_done2", done, 4'b0100);
    req = '0;
    tick();
    tick();

    // Zero ticks: grant and done together for one cycle.
    do_reset();
    set_ticks(3, 0);
    req = 4'b1000;
    tick();
    check("t3_grant", grant, 4'b1000);
    check("t3_done", done, 4'b1000);
    req = '0;
    tick();
    check("t3_grant_off", grant, 0);
    check("t3_done_off", done, 0);

    // Withdrawal mid-run: no done.
    do_reset();
    set_ticks(2, 5);
    req = 4'b0100;
    tick();
    check("t4_grant", grant, 4'b0100);
    repeat (7) tick();
    req = '0;
    tick();
    check("t4_grant_off", grant, 0);
    check("t4_no_done", done, 0);
    check("t4_busy", busy, 0);
    check("t4_remaining", remaining, 0);

    // Reset mid-run aborts; a later request is served normally.
    do_reset();
    set_ticks(0, 4);
    req = 4'b0001;
    tick();
    check("t5_grant", grant, 4'b0001);
    repeat (5) tick();
    reset = 1'b1;
    req = '0;
    tick();
    check("t5_rst_grant", grant, 0);
    check("t5_rst_done", done, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_cur_id", cur_id, 0);
    check("t5_rst_remaining", remaining, 0);
    reset = 1'b0;
    set_ticks(1, 1);
    req = 4'b0010;
    tick();
    check("t5_regrant", grant, 4'b0010);
    wait_done(20, n);
    check("t5_redone", done, 4'b0010);
    req = '0;
    tick();
    tick();

    // All requests held: arbitration order.
    do_reset();
    for (int i = 0; i < N; i++) set_ticks(i, 1);
`ifdef TIMER_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    req  = 4'b1111;
    prev = '0;
    cnt  = 0;
    n    = 0;
    while (cnt < 5 && n < 200) begin
      tick();
      n++;
      if (grant != '0 && prev == '0) begin
        got[cnt] = idx_of(grant);
        cnt++;
      end
      prev = grant;
    end
    check("t6_count", cnt, 5);
    for (int i = 0; i < 5; i++) check($sformatf("t6_order%0d", i), got[i], exp_order[i]);
    req = '0;
    tick();
    tick();
    tick();

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 19) == 0) req[i] = ~req[i];
        if ($urandom_range(0, 9) == 0) set_ticks(i, int'($urandom_range(0, 5)));
      end
      tick();
    end
    reset = 1'b0;
    req = '0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
